fetch_address_unit: RTL and testbench

FETCH_ADDRESS_UNIT -- requirements
Module: fetch_address_unit

---
 rtl/fetch_address_unit.sv | 126 ++++++++++++
 tb/tb_fetch_address_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_address_unit.sv
// Fetch address unit: PC sequencing, jump flush, data-bus borrowing and halt.
// Optional jump-target alignment checking is enabled with macro PC_ALIGN_CHECK_EN.
module fetch_address_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc_pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        data_access_req,
    input  logic [29:0] data_address,
    input  logic        halt,
    output logic [29:0] mem_address,
    output logic        insert_nop,
    output logic [31:0] pc,
    output logic        misaligned
);

    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_mis_set;
    logic             w_bad_target;

`ifdef PC_ALIGN_CHECK_EN
    assign w_bad_target = (jump_target[1:0] != 2'b00);
`else
    assign w_bad_target = 1'b0;
`endif

    // Next-state decode; priority is halt > jump > data_access_req > inc_pc.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_mis_set   = 1'b0;
        if (r_state != HALTED) begin
            if (halt) begin
                w_state_nxt = HALTED;
            end else if (jump) begin
                if (w_bad_target) begin
                    w_mis_set   = 1'b1;
                    w_state_nxt = HALTED;
                end else begin
                    w_pc_nxt    = {jump_target[31:2], 2'b00};
                    w_cnt_nxt   = CNT_W'(FLUSH_CYCLES);
                    w_state_nxt = FLUSH;
                end
            end else begin
                case (r_state)
                    RUN: begin
                        if (data_access_req) begin
                            w_state_nxt = DATA;
                        end else if (inc_pc) begin
                            w_pc_nxt = r_pc + 32'd4;
                        end
                    end
                    DATA: begin
                        if (!data_access_req) begin
                            w_state_nxt = RUN;
                        end
                    end
                    FLUSH: begin
                        // Pending data requests wait until the flush drains.
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                        if (r_cnt <= CNT_W'(1)) begin
                            w_state_nxt = RUN;
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;

    // Sticky until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_misaligned <= 1'b0;
        end else if (w_mis_set) begin
            r_misaligned <= 1'b1;
        end
    end

    assign misaligned = r_misaligned;
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_mis_set, jump_target[1:0]};
    assign misaligned  = 1'b0;
`endif

    assign pc          = r_pc;
    assign insert_nop  = (r_state != RUN);
    assign mem_address = (r_state == DATA) ? data_address : r_pc[31:2];

endmodule

// File: tb/tb_fetch_address_unit.sv
// Directed self-checking bench for fetch_address_unit (default parameters).
module tb_fetch_address_unit;

    logic        clock;
    logic        reset;
    logic        inc_pc;
    logic        jump;
    logic [31:0] jump_target;
    logic        data_access_req;
    logic [29:0] data_address;
    logic        halt;
    logic [29:0] mem_address;
    logic        insert_nop;
    logic [31:0] pc;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    fetch_address_unit dut (
        .clock          (clock),
        .reset          (reset),
        .inc_pc         (inc_pc),
        .jump           (jump),
        .jump_target    (jump_target),
        .data_access_req(data_access_req),
        .data_address   (data_address),
        .halt           (halt),
        .mem_address    (mem_address),
        .insert_nop     (insert_nop),
        .pc             (pc),
        .misaligned     (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Checks pc, insert_nop, mem_address together.
    task automatic chk3(input string tag, input logic [31:0] e_pc, input logic e_nop,
                        input logic [29:0] e_mem);
        check({tag, "_pc"}, pc, e_pc);
        check({tag, "_nop"}, 32'(insert_nop), 32'(e_nop));
        check({tag, "_mem"}, 32'(mem_address), 32'(e_mem));
    endtask

    initial begin
        reset = 1'b0; inc_pc = 1'b0; jump = 1'b0; jump_target = 32'h0;
        data_access_req = 1'b0; data_address = 30'h0; halt = 1'b0;
        #2;
        chk3("reset", 32'h0, 1'b0, 30'h0);
        check("reset_mis", 32'(misaligned), 32'h0);
        step(); step();
        reset = 1'b1;

        // Sequential fetch
        inc_pc = 1'b1;
        chk3("seq0", 32'h0, 1'b0, 30'h0);
        step(); chk3("seq4", 32'h4, 1'b0, 30'h1);
        step(); chk3("seq8", 32'h8, 1'b0, 30'h2);
        step(); chk3("seqC", 32'hC, 1'b0, 30'h3);
        step(); chk3("seq10", 32'h10, 1'b0, 30'h4);
        inc_pc = 1'b0;
        step(); chk3("hold10", 32'h10, 1'b0, 30'h4);

        // Get to 0x20 via jump
        jump = 1'b1; jump_target = 32'h20;
        step(); jump = 1'b0;
        chk3("j20_f1", 32'h20, 1'b1, 30'h8);
        step(); chk3("j20_f2", 32'h20, 1'b1, 30'h8);
        step(); chk3("j20_run", 32'h20, 1'b0, 30'h8);

        // Jump to 0x100 with inc_pc held: 2 NOP cycles then advance
        jump = 1'b1; jump_target = 32'h100; inc_pc = 1'b1;
        step(); jump = 1'b0;
        chk3("j100_f1", 32'h100, 1'b1, 30'h40);
        step(); chk3("j100_f2", 32'h100, 1'b1, 30'h40);
        step(); chk3("j100_run", 32'h100, 1'b0, 30'h40);
        step(); chk3("j100_adv", 32'h104, 1'b0, 30'h41);
        inc_pc = 1'b0;

        // Data access at pc 0x40
        jump = 1'b1; jump_target = 32'h40;
        step(); jump = 1'b0;
        step(); step();
        chk3("at40", 32'h40, 1'b0, 30'h10);
        data_access_req = 1'b1; data_address = 30'h200; inc_pc = 1'b1;
        step(); chk3("data1", 32'h40, 1'b1, 30'h200);
        step(); chk3("data2", 32'h40, 1'b1, 30'h200);
        step(); chk3("data3", 32'h40, 1'b1, 30'h200);
        data_access_req = 1'b0;
        step(); chk3("data_exit", 32'h40, 1'b0, 30'h10);
        step(); chk3("data_resume", 32'h44, 1'b0, 30'h11);
        inc_pc = 1'b0;

        // Data request during flush is deferred
        jump = 1'b1; jump_target = 32'h80;
        step(); jump = 1'b0;
        data_access_req = 1'b1;
        step(); chk3("defer_f2", 32'h80, 1'b1, 30'h20);
        step(); chk3("defer_run", 32'h80, 1'b0, 30'h20);
        step(); chk3("defer_data", 32'h80, 1'b1, 30'h200);
        data_access_req = 1'b0;
        step(); chk3("defer_back", 32'h80, 1'b0, 30'h20);

        // Jump during flush restarts the flush
        jump = 1'b1; jump_target = 32'h300;
        step(); chk3("rj_f1", 32'h300, 1'b1, 30'hC0);
        jump_target = 32'h400;
        step(); jump = 1'b0;
        chk3("rj_f1b", 32'h400, 1'b1, 30'h100);
        step(); chk3("rj_f2b", 32'h400, 1'b1, 30'h100);
        step(); chk3("rj_run", 32'h400, 1'b0, 30'h100);

        // Wrap at top of address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step(); jump = 1'b0;
        step(); step();
        chk3("top", 32'hFFFF_FFFC, 1'b0, 30'h3FFF_FFFF);
        inc_pc = 1'b1;
        step(); chk3("wrap", 32'h0, 1'b0, 30'h0);
        inc_pc = 1'b0;

        // Unaligned jump target
        jump = 1'b1; jump_target = 32'h102;
        step(); jump = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk3("mis_halt", 32'h0, 1'b1, 30'h0);
        check("mis_flag", 32'(misaligned), 32'h1);
        reset = 1'b0; #1;
        chk3("mis_rst", 32'h0, 1'b0, 30'h0);
        check("mis_clr", 32'(misaligned), 32'h0);
        reset = 1'b1;
        jump = 1'b1; jump_target = 32'h100;
        step(); jump = 1'b0;
`else
        chk3("unal_f1", 32'h100, 1'b1, 30'h40);
        check("unal_mis", 32'(misaligned), 32'h0);
`endif
        step(); step();
        chk3("at100", 32'h100, 1'b0, 30'h40);

        // Halt beats jump; halted state ignores inputs
        halt = 1'b1; jump = 1'b1; jump_target = 32'h500;
        step(); chk3("halt", 32'h100, 1'b1, 30'h40);
        halt = 1'b0; data_access_req = 1'b1; inc_pc = 1'b1;
        step(); chk3("halt_hold1", 32'h100, 1'b1, 30'h40);
        step(); chk3("halt_hold2", 32'h100, 1'b1, 30'h40);
        jump = 1'b0; data_access_req = 1'b0;

        // Asynchronous reset from halted
        reset = 1'b0; #1;
        chk3("rst_halt", 32'h0, 1'b0, 30'h0);
        step();
        reset = 1'b1;
        step(); chk3("rst_fetch", 32'h4, 1'b0, 30'h1);

        // Asynchronous reset mid-data
        inc_pc = 1'b0; data_access_req = 1'b1;
        step(); chk3("pre_rst_data", 32'h4, 1'b1, 30'h200);
        reset = 1'b0; #1;
        chk3("rst_data", 32'h0, 1'b0, 30'h0);
        data_access_req = 1'b0;
        step();
        reset = 1'b1;
        step(); chk3("post_rst_data", 32'h0, 1'b0, 30'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
